// File: rtl/mem_transfer_pkg.sv
// rtl/mem_transfer_pkg.sv - shared widths and FSM state type for the subtract transfer stage
package mem_transfer_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } xfer_state_t;

endpackage

// File: rtl/mem_sub_transfer_ctrl.sv
// rtl/mem_sub_transfer_ctrl.sv - sequences operand pairs from mem1 through the subtracter into mem2
module mem_sub_transfer_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem1_addr,
    output logic              mem1_re,
    input  logic [DATA_W-1:0] mem1_dout,
    output logic [DATA_W-1:0] DOut2,
    output logic [DATA_W-1:0] DOut1,
    input  logic [DATA_W-1:0] SUBOut,
    output logic [ADDR_W-1:0] mem2_addr,
    output logic              mem2_we,
    output logic [DATA_W-1:0] mem2_din,
    output logic              busy,
    output logic              done
);
    import mem_transfer_pkg::*;

    xfer_state_t       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic [DATA_W-1:0] dout2_q, dout2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
        end
    end

    // Outputs decode from the registered state so reset drives them to 0 at once.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        dout1_d   = dout1_q;
        dout2_d   = dout2_q;
        mem1_re   = 1'b0;
        mem1_addr = '0;
        mem2_we   = 1'b0;
        mem2_addr = '0;
        mem2_din  = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                mem1_re   = 1'b1;
                mem1_addr = src_q;
                state_d   = RD_B;
            end
            RD_B: begin
                mem1_re   = 1'b1;
                mem1_addr = src_q + ADDR_W'(1);
                dout2_d   = mem1_dout;
                state_d   = CAP_B;
            end
            CAP_B: begin
                dout1_d = mem1_dout;
                state_d = WR;
            end
            WR: begin
                mem2_we   = 1'b1;
                mem2_addr = dst_q;
                mem2_din  = SUBOut;
                src_d     = src_q + ADDR_W'(2);
                dst_d     = dst_q + ADDR_W'(1);
                cnt_d     = cnt_q - ADDR_W'(1);
                state_d   = (cnt_q == ADDR_W'(1)) ? DONE : RD_A;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign DOut1 = dout1_q;
    assign DOut2 = dout2_q;

endmodule

// File: tb/tb_mem_sub_transfer_ctrl.sv
// tb/tb_mem_sub_transfer_ctrl.sv - vector-table bench for mem_sub_transfer_ctrl
module tb_mem_sub_transfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] src_base, dst_base, len;
    logic [3:0] mem1_addr;
    logic       mem1_re;
    logic [7:0] mem1_dout;
    logic [7:0] DOut2, DOut1, SUBOut;
    logic [3:0] mem2_addr;
    logic       mem2_we;
    logic [7:0] mem2_din;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem1 [16];
    logic [7:0] mem1_rd = 8'h00;

    mem_sub_transfer_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .mem1_addr(mem1_addr), .mem1_re(mem1_re), .mem1_dout(mem1_dout),
        .DOut2(DOut2), .DOut1(DOut1), .SUBOut(SUBOut),
        .mem2_addr(mem2_addr), .mem2_we(mem2_we), .mem2_din(mem2_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem1_re) mem1_rd <= mem1[mem1_addr];
    assign mem1_dout = mem1_rd;
    assign SUBOut    = DOut2 - DOut1;

    typedef struct packed {
        logic [3:0]       src;
        logic [3:0]       dst;
        logic [3:0]       len;
        logic [7:0]       inj;
        logic [7:0]       done_cyc;
        logic [3:0][3:0]  raddr;
        logic [3:0][3:0]  waddr;
        logic [3:0][7:0]  wdata;
    } vec_t;

    vec_t vecs [5];

    int rd_q [$];
    int wa_q [$];
    int wd_q [$];
    int wc_q [$];
    int done_cnt;
    int done_at;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int id);
        int  cyc;
        bit  fin;
        rd_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0;
        done_at  = -1;
        fin      = 1'b0;
        @(posedge clk); #1;
        src_base = v.src; dst_base = v.dst; len = v.len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk($sformatf("v%0d busy_c1", id), busy, 1);
            if (mem1_re) rd_q.push_back(mem1_addr);
            if (mem2_we) begin
                wa_q.push_back(mem2_addr);
                wd_q.push_back(mem2_din);
                wc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at > 0 && cyc == done_at + 1) begin
                chk($sformatf("v%0d busy_after_done", id), busy, 0);
                fin = 1'b1;
            end
            if (v.inj != 0 && cyc == int'(v.inj)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!fin) chk($sformatf("v%0d timeout", id), 0, 1);
        chk($sformatf("v%0d done_cycle", id), done_at, v.done_cyc);
        chk($sformatf("v%0d done_count", id), done_cnt, 1);
        chk($sformatf("v%0d n_reads", id), rd_q.size(), 2 * int'(v.len));
        chk($sformatf("v%0d n_writes", id), wa_q.size(), v.len);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            chk($sformatf("v%0d raddr%0d", id, i), rd_q[i], v.raddr[i]);
        for (int i = 0; i < 4 && i < wa_q.size() && i < int'(v.len); i++) begin
            chk($sformatf("v%0d waddr%0d", id, i), wa_q[i], v.waddr[i]);
            chk($sformatf("v%0d wdata%0d", id, i), wd_q[i], v.wdata[i]);
            chk($sformatf("v%0d wcyc%0d", id, i), wc_q[i], 4 * (i + 1));
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, {mem1_addr, mem1_re, mem2_addr, mem2_we, busy, done}, 0);
        chk({nm, "_b"}, {DOut1, DOut2, mem2_din}, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem1[i] = 8'h00;
        mem1[0] = 8'h89; mem1[1] = 8'h03; mem1[2] = 8'hE3; mem1[3] = 8'hFC;
        mem1[4] = 8'h1B; mem1[5] = 8'h53; mem1[6] = 8'hE3; mem1[7] = 8'h53;
        mem1[15] = 8'h50;

        vecs[0] = '{src: 4'd0, dst: 4'd0, len: 4'd1, inj: 8'd0, done_cyc: 8'd5,
                    raddr: {4'd0, 4'd0, 4'd1, 4'd0},
                    waddr: {4'd0, 4'd0, 4'd0, 4'd0},
                    wdata: {8'h00, 8'h00, 8'h00, 8'h86}};
        vecs[1] = '{src: 4'd0, dst: 4'd4, len: 4'd4, inj: 8'd0, done_cyc: 8'd17,
                    raddr: {4'd3, 4'd2, 4'd1, 4'd0},
                    waddr: {4'd7, 4'd6, 4'd5, 4'd4},
                    wdata: {8'h90, 8'hC8, 8'hE7, 8'h86}};
        vecs[2] = '{src: 4'd5, dst: 4'd3, len: 4'd0, inj: 8'd0, done_cyc: 8'd1,
                    raddr: 16'h0, waddr: 16'h0, wdata: 32'h0};
        vecs[3] = '{src: 4'd15, dst: 4'd15, len: 4'd2, inj: 8'd0, done_cyc: 8'd9,
                    raddr: {4'd2, 4'd1, 4'd0, 4'd15},
                    waddr: {4'd0, 4'd0, 4'd0, 4'd15},
                    wdata: {8'h00, 8'h00, 8'h20, 8'hC7}};
        vecs[4] = '{src: 4'd2, dst: 4'd8, len: 4'd3, inj: 8'd6, done_cyc: 8'd13,
                    raddr: {4'd5, 4'd4, 4'd3, 4'd2},
                    waddr: {4'd0, 4'd10, 4'd9, 4'd8},
                    wdata: {8'h00, 8'h90, 8'hC8, 8'hE7}};

        rst = 1'b1; start = 1'b0;
        src_base = '0; dst_base = '0; len = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 5; k++) run_job(vecs[k], k);

        // Abort pair 1 of a 4-pair job in its RD_B cycle, then restart cleanly.
        @(posedge clk); #1;
        src_base = 4'd0; dst_base = 4'd4; len = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 6) begin
                chk("rst_pre_re", mem1_re, 1);
                chk("rst_pre_addr", mem1_addr, 3);
            end
        end
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_we%0d", c), {mem2_we, busy}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(vecs[0], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_sub_transfer_ctrl.md
# mem_sub_transfer_ctrl

Sequencing stage that drives the 8-bit subtracter in the memory-to-memory transfer path. It reads operand pairs from source memory, registers them onto the subtracter inputs `DOut2` (minuend) and `DOut1` (subtrahend), and writes each `SUBOut` result into destination memory. It is started by a one-cycle command and reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 4: address width of both memories.
- `DATA_W`, 8: data width; matches the subtracter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; ignored while `busy`.
- `src_base`  in  ADDR_W  first source address; sampled on the accepted `start`.
- `dst_base`  in  ADDR_W  first destination address; sampled on the accepted `start`.
- `len`  in  ADDR_W  number of operand pairs; sampled on the accepted `start`.
- `mem1_addr`  out  ADDR_W  source read address.
- `mem1_re`  out  1  source read enable.
- `mem1_dout`  in  DATA_W  source read data; valid the cycle after `mem1_re`.
- `DOut2`  out  DATA_W  minuend register feeding the subtracter.
- `DOut1`  out  DATA_W  subtrahend register feeding the subtracter.
- `SUBOut`  in  DATA_W  combinational `DOut2 - DOut1` from the subtracter.
- `mem2_addr`  out  ADDR_W  destination write address.
- `mem2_we`  out  1  destination write enable.
- `mem2_din`  out  DATA_W  destination write data.
- `busy`  out  1  high from the cycle after an accepted `start` through the `DONE` cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Pair i: minuend = `mem1[src_base+2i]`, subtrahend = `mem1[src_base+2i+1]`; result goes to `mem2[dst_base+i]`.
- All address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
- FSM states: `IDLE`, `RD_A`, `RD_B`, `CAP_B`, `WR`, `DONE`.
  - `IDLE`: on `start`, latch the bases and `len`. Go to `DONE` if `len==0`, else to `RD_A`.
  - `RD_A`: `mem1_re=1`, `mem1_addr`=src pointer.
  - `RD_B`: `mem1_re=1`, `mem1_addr`=src pointer+1; load `DOut2` from `mem1_dout`.
  - `CAP_B`: load `DOut1` from `mem1_dout`.
  - `WR`: `mem2_we=1`, `mem2_addr`=dst pointer, `mem2_din`=`SUBOut`. Then src pointer += 2, dst pointer += 1, remaining count -= 1. Go to `DONE` if the count reaches 0, else to `RD_A`.
  - `DONE`: `done=1`; next state is `IDLE`.
- `DOut1`/`DOut2` hold their values between loads. The result is a wrap-around 8-bit difference; there is no borrow output.
- `start` asserted in any state other than `IDLE` is dropped, with no queueing.
- Reset at any point forces `IDLE` immediately. A transfer in progress is abandoned; no partial write completes after reset asserts.

## Timing
- Reset values: every output is 0 (`mem1_addr`, `mem1_re`, `DOut1`, `DOut2`, `mem2_addr`, `mem2_we`, `mem2_din`, `busy`, `done`); the FSM is in `IDLE`.
- Cycle numbering: cycle 1 is the first cycle after the edge that samples `start`.
- Pair i occupies cycles 4i+1 through 4i+4:
  - `RD_A` in cycle 4i+1.
  - `RD_B` in cycle 4i+2.
  - `CAP_B` in cycle 4i+3.
  - `WR` in cycle 4i+4.
- `done` is high in cycle 4·len+1; for `len==0` this is cycle 1. `busy` falls in the following cycle.
- A new `start` is accepted one cycle after `done` at the earliest.
- Source memory is assumed to have exactly one cycle of read latency. `mem2` captures the write on the rising edge at the end of the `WR` cycle.

## Structure
- Package `mem_transfer_pkg`: `ADDR_W`/`DATA_W` defaults and the state enumeration type `xfer_state_t`.
- A single module, with no sub-module required. The src/dst pointers and the remaining-pair counter stay inline in the FSM.

## Test plan
- Single pair: `mem1[0]=0x89`, `mem1[1]=0x03`, `len=1`, bases 0. Required: `mem2[0]=0x86`, `done` in cycle 5.
- Four pairs, `src_base=0`, `dst_base=4`, operands (0x89,0x03), (0xE3,0xFC), (0x1B,0x53), (0xE3,0x53). Required: `mem2[4..7]` = 0x86, 0xE7, 0xC8, 0x90; `mem2_we` high in cycles 4, 8, 12, 16; `done` in cycle 17.
- `len=0`: `done` in cycle 1; `mem1_re` and `mem2_we` never assert.
- Wrap: `ADDR_W=4`, `src_base=15`, `dst_base=15`, `len=2`. Required:
  - Reads hit addresses 15, 0, 1, 2.
  - Writes hit addresses 15 and 0.
- `start` pulsed during cycle 6 of a 3-pair job: ignored; exactly 3 writes occur and one `done` pulse.
- `rst` asserted mid-`RD_B` of pair 1 of 4. Required:
  - All outputs read 0 immediately.
  - No further `mem2_we`.
  - A fresh `start` after reset completes normally.
